// File: rtl/mcdp_pkg.sv
// Shared types and encodings for the multicycle data path.
// States, op classes, ALU commands and condition codes.
package mcdp_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB
   } state_t;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_AL = 4'b1110;

   function automatic logic cond_pass(
      input logic [3:0] c,
      input logic       z
   );
      case (c)
         COND_AL: return 1'b1;
         COND_EQ: return z;
         COND_NE: return !z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic cmd_ok(input logic [3:0] c);
      return (c == CMD_ADD) || (c == CMD_SUB) ||
             (c == CMD_AND) || (c == CMD_ORR);
   endfunction

endpackage

// File: rtl/reg_file_param.sv
// Register file: two async read ports, one sync write port,
// async active-low clear of every entry.
module reg_file_param #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [AW-1:0]    wa,
   input  logic [WIDTH-1:0] wd
);

   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

endmodule

// File: rtl/multicycle_data_path.sv
// Five-state multicycle core: fetch, decode, execute,
// memory, write-back over one shared memory port.
module multicycle_data_path
   import mcdp_pkg::*;
#(
   parameter int               WIDTH    = 32,
   parameter int               NREGS    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_ready,
   output logic [WIDTH-1:0] pc,
   output logic [3:0]       alu_flags,
   output logic             retire
);

   localparam int AW = $clog2(NREGS);
   localparam bit PC_ALIAS = (NREGS == 16);

   state_t           state_q, state_d;
   logic [31:0]      ir_q;
   logic [WIDTH-1:0] pc_q, pc_d, a_q, b_q, res_q, res_d;
   logic [3:0]       nzcv_q;
   logic             ld_ir, ld_ab, ld_res, ld_flags, rf_we;
   logic             req_c, we_c, ret_c;

   wire [3:0]  cond  = ir_q[31:28];
   wire [1:0]  op    = ir_q[27:26];
   wire        i_bit = ir_q[25];
   wire [3:0]  cmd   = ir_q[24:21];
   wire        s_bit = ir_q[20];
   wire [3:0]  rn    = ir_q[19:16];
   wire [3:0]  rd    = ir_q[15:12];
   wire [3:0]  rm    = ir_q[3:0];
   wire [11:0] imm12 = ir_q[11:0];

   wire [WIDTH-1:0] pc4 = pc_q + WIDTH'(4);
   wire [WIDTH-1:0] pc8 = pc_q + WIDTH'(8);
   wire rd_is_pc = PC_ALIAS && (rd == 4'hF);

   logic [WIDTH-1:0] rd1, rd2;
   wire [AW-1:0] ra2 =
      (state_q == S_DECODE) ? rm[AW-1:0] : rd[AW-1:0];

   reg_file_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .clk  (clk),
      .rst_n(rst),
      .ra1  (rn[AW-1:0]),
      .ra2  (ra2),
      .rd1  (rd1),
      .rd2  (rd2),
      .we   (rf_we),
      .wa   (rd[AW-1:0]),
      .wd   (res_q)
   );

   // R15 reads see pc+8 when the file is large enough to alias it
   wire [WIDTH-1:0] opa =
      (PC_ALIAS && rn == 4'hF) ? pc8 : rd1;
   wire [WIDTH-1:0] opb =
      (PC_ALIAS && rm == 4'hF) ? pc8 : rd2;
   assign mem_wdata = rd_is_pc ? pc8 : rd2;

   wire [WIDTH-1:0] op2 = i_bit ? WIDTH'(imm12) : b_q;
   wire [WIDTH:0] add_w = {1'b0, a_q} + {1'b0, op2};
   wire [WIDTH:0] sub_w =
      {1'b0, a_q} + {1'b0, ~op2} + (WIDTH + 1)'(1);

   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (cmd)
         CMD_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] == op2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         CMD_SUB: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = sub_w[WIDTH];
            alu_v   = (a_q[WIDTH-1] != op2[WIDTH-1]) &&
                      (alu_res[WIDTH-1] != a_q[WIDTH-1]);
         end
         CMD_AND: alu_res = a_q & op2;
         CMD_ORR: alu_res = a_q | op2;
         default: alu_res = '0;
      endcase
   end

   wire [31:0] boff = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
   wire [WIDTH-1:0] br_tgt = pc8 + boff[WIDTH-1:0];
   wire wb_wr = (op == OP_MEM) || (op == OP_DP && cmd_ok(cmd));

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      res_d    = res_q;
      ld_ir    = 1'b0;
      ld_ab    = 1'b0;
      ld_res   = 1'b0;
      ld_flags = 1'b0;
      rf_we    = 1'b0;
      req_c    = 1'b0;
      we_c     = 1'b0;
      ret_c    = 1'b0;
      mem_addr = pc_q;
      unique case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               ld_ir   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            ld_ab = 1'b1;
            if (cond_pass(cond, nzcv_q[2])) begin
               state_d = S_EXEC;
            end else begin
               ret_c   = 1'b1;
               pc_d    = pc4;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            unique case (op)
               OP_DP: begin
                  ld_res   = 1'b1;
                  res_d    = alu_res;
                  ld_flags = s_bit && cmd_ok(cmd);
                  state_d  = S_WB;
               end
               OP_MEM: begin
                  ld_res  = 1'b1;
                  res_d   = a_q + WIDTH'(imm12);
                  state_d = S_MEM;
               end
               OP_BR: begin
                  pc_d    = br_tgt;
                  ret_c   = 1'b1;
                  state_d = S_FETCH;
               end
               OP_ILL: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            req_c    = 1'b1;
            we_c     = !s_bit;
            mem_addr = res_q;
            if (mem_ready) begin
               if (s_bit) begin
                  ld_res  = 1'b1;
                  res_d   = mem_rdata[WIDTH-1:0];
                  state_d = S_WB;
               end else begin
                  ret_c   = 1'b1;
                  pc_d    = pc4;
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            ret_c   = 1'b1;
            state_d = S_FETCH;
            pc_d    = (wb_wr && rd_is_pc) ? res_q : pc4;
            rf_we   = wb_wr && !rd_is_pc;
         end
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         nzcv_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (ld_ir) ir_q <= mem_rdata;
         if (ld_ab) begin
            a_q <= opa;
            b_q <= opb;
         end
         if (ld_res) res_q <= res_d;
         if (ld_flags) begin
            nzcv_q <= {alu_res[WIDTH-1], alu_res == '0,
                       alu_c, alu_v};
         end
      end
   end

   // reset drops the handshake outputs without waiting for a clock
   assign mem_req   = req_c & rst;
   assign mem_we    = we_c & rst;
   assign retire    = ret_c & rst;
   assign pc        = pc_q;
   assign alu_flags = nzcv_q;

endmodule

// File: tb/tb_multicycle_data_path.sv
// Directed bench: short program run from RESET_PC with a
// stalling memory model, plus a 16-bit pc wrap instance.
module tb_multicycle_data_path;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_req, mem_we, mem_ready, retire;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
   logic [3:0]  alu_flags;

   logic        req16, we16, retire16;
   logic [15:0] addr16, wdata16, pc16;
   logic [3:0]  flags16;

   logic [31:0] mem [256];
   logic [31:0] stall_addr = 32'hFFFF_FFF0;
   int          stall_len = 0;
   int          stall_cnt = 0;
   int          checks = 0;
   int          errors = 0;
   int          n;

   always #5 clk = ~clk;

   multicycle_data_path dut (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_ready(mem_ready),
      .pc       (pc),
      .alu_flags(alu_flags),
      .retire   (retire)
   );

   multicycle_data_path #(
      .WIDTH(16), .NREGS(16), .RESET_PC(16'hFFFC)
   ) u16 (
      .clk      (clk),
      .rst      (rst),
      .mem_req  (req16),
      .mem_we   (we16),
      .mem_addr (addr16),
      .mem_wdata(wdata16),
      .mem_rdata(32'hE2811003),
      .mem_ready(1'b1),
      .pc       (pc16),
      .alu_flags(flags16),
      .retire   (retire16)
   );

   wire hit = mem_req && (mem_addr == stall_addr);
   assign mem_ready = !(hit && stall_cnt < stall_len);
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (hit && stall_cnt < stall_len)
         stall_cnt <= stall_cnt + 1;
      else if (!hit)
         stall_cnt <= 0;
   end

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic next_retire(output int cnt);
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!retire && cnt < 64);
      chk("retire_seen", 32'(retire), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'hE2801063;
      mem[0]  = 32'hE2801005;
      mem[1]  = 32'hE2811003;
      mem[2]  = 32'hE2802007;
      mem[3]  = 32'hE2803007;
      mem[4]  = 32'hE0522003;
      mem[5]  = 32'h0A000002;
      mem[9]  = 32'h12811001;
      mem[10] = 32'h32811001;
      mem[11] = 32'hE2804FFF;
      mem[12] = 32'hE2844235;
      mem[13] = 32'hE2800100;
      mem[14] = 32'hE4004008;
      mem[15] = 32'hE4001000;
      mem[16] = 32'hE4002004;
      mem[17] = 32'hE4105010;
      mem[18] = 32'hE4005014;
      mem[19] = 32'hEC000000;
      mem[20] = 32'hE4000000;
      mem[21] = 32'hE28FF004;
      mem[24] = 32'hE4001000;
      mem[68] = 32'hDEADBEEF;

      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_retire", 32'(retire), 32'd0);
      chk("rst_flags", 32'(alu_flags), 32'h0);
      chk("rst_pc16", 32'(pc16), 32'hFFFC);

      rst = 1'b1;
      #1;
      chk("fetch_req", 32'(mem_req), 32'd1);
      chk("fetch_addr", mem_addr, 32'h0);

      next_retire(n);
      chk("w16_retire", 32'(retire16), 32'd1);
      chk("w16_pc_pre", 32'(pc16), 32'hFFFC);

      next_retire(n);
      chk("add_lat", n, 4);
      chk("add_pc", pc, 32'h4);
      chk("w16_pc_wrap", 32'(pc16), 32'h0);

      next_retire(n);
      next_retire(n);
      next_retire(n);
      chk("subs_lat", n, 4);
      chk("subs_flags", 32'(alu_flags), 32'h6);

      next_retire(n);
      chk("b_lat", n, 3);
      chk("b_pc", pc, 32'h14);

      next_retire(n);
      chk("ne_lat", n, 2);
      chk("ne_pc", pc, 32'h24);
      next_retire(n);
      chk("nv_lat", n, 2);
      chk("nv_pc", pc, 32'h28);

      next_retire(n);
      next_retire(n);
      next_retire(n);

      next_retire(n);
      chk("str_lat", n, 4);
      chk("str_pc", pc, 32'h38);
      chk("str_we", 32'(mem_we), 32'd1);
      chk("str_addr", mem_addr, 32'h108);
      chk("str_data", mem_wdata, 32'h1234);

      next_retire(n);
      chk("r1_data", mem_wdata, 32'h8);
      chk("r1_addr", mem_addr, 32'h100);
      next_retire(n);
      chk("r2_data", mem_wdata, 32'h0);

      stall_addr = 32'h110;
      stall_len  = 3;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c >= 4 && c <= 7) begin
            chk("ldr_req", 32'(mem_req), 32'd1);
            chk("ldr_we", 32'(mem_we), 32'd0);
            chk("ldr_addr", mem_addr, 32'h110);
         end
         if (c == 7) chk("ldr_early", 32'(retire), 32'd0);
         if (c == 8) chk("ldr_retire", 32'(retire), 32'd1);
      end

      next_retire(n);
      chk("ldr_val", mem_wdata, 32'hDEADBEEF);
      chk("ldr_st_addr", mem_addr, 32'h114);

      next_retire(n);
      chk("ill_pc", pc, 32'h4C);
      next_retire(n);
      chk("ill_next_pc", pc, 32'h50);
      chk("ill_r0", mem_wdata, 32'h100);

      next_retire(n);
      chk("pcw_pc", pc, 32'h54);
      stall_addr = 32'h64;
      stall_len  = 1000;
      next_retire(n);
      chk("pcw_tgt", pc, 32'h60);
      chk("pcw_r1", mem_wdata, 32'h8);

      @(negedge clk);
      chk("fw_req", 32'(mem_req), 32'd1);
      chk("fw_addr", mem_addr, 32'h64);
      chk("fw_stall", 32'(mem_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      chk("mid_req", 32'(mem_req), 32'd0);
      chk("mid_pc", pc, 32'h0);
      chk("mid_flags", 32'(alu_flags), 32'h0);
      chk("mid_retire", 32'(retire), 32'd0);

      mem[0] = 32'hE4001000;
      mem[1] = 32'hE4004008;
      stall_len = 0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_req", 32'(mem_req), 32'd1);
      chk("rel_addr", mem_addr, 32'h0);

      next_retire(n);
      chk("rel_lat", n, 3);
      chk("clr_r1", mem_wdata, 32'h0);
      chk("clr_r1_addr", mem_addr, 32'h0);
      next_retire(n);
      chk("clr_r4", mem_wdata, 32'h0);
      chk("clr_r4_addr", mem_addr, 32'h8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
